ins_encoder: RTL and testbench

INS_ENCODER -- requirements
Module: ins_encoder

---
 rtl/ins_encoder.sv | 139 +++++++++++++
 tb/tb_ins_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_encoder.sv
// Serialises one instruction's prefix/opcode/ModRM/SIB/disp/imm fields into a byte stream.
// First byte one cycle after capture, one byte per out_ready; out_valid/out_byte hold while stalled.
module ins_encoder #(
  parameter int MAX_LEN = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        lr_en,
  input  logic        seg_en,
  input  logic        osz_en,
  input  logic        asz_en,
  input  logic        rex_en,
  input  logic [7:0]  lr_byte,
  input  logic [7:0]  seg_byte,
  input  logic [7:0]  rex_byte,
  input  logic [23:0] opc,
  input  logic [1:0]  opc_len,
  input  logic        modrm_en,
  input  logic        sib_en,
  input  logic [7:0]  modrm,
  input  logic [7:0]  sib,
  input  logic [31:0] disp,
  input  logic [31:0] imm,
  input  logic [2:0]  disp_len,
  input  logic [2:0]  imm_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [3:0]  out_len,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, EMIT, ERR} state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] len_q, len_d;
  logic [7:0] buf_q [MAX_LEN];
  logic [7:0] buf_d [MAX_LEN];

  logic [7:0]  cand [18];
  logic [17:0] cen;
  logic [4:0]  len_calc;
  logic        bad;

  function automatic logic size_ok(input logic [2:0] n);
    return (n == 3'd0) || (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
  endfunction

  // Every possible byte in emission order, each with its own presence bit.
  always_comb begin
    cand[0] = lr_byte;        cen[0] = lr_en;
    cand[1] = seg_byte;       cen[1] = seg_en;
    cand[2] = 8'h66;          cen[2] = osz_en;
    cand[3] = 8'h67;          cen[3] = asz_en;
    cand[4] = rex_byte;       cen[4] = rex_en;
    cand[5] = opc[23:16];     cen[5] = (opc_len >= 2'd1);
    cand[6] = opc[15:8];      cen[6] = (opc_len >= 2'd2);
    cand[7] = opc[7:0];       cen[7] = (opc_len == 2'd3);
    cand[8] = modrm;          cen[8] = modrm_en;
    cand[9] = sib;            cen[9] = sib_en;
    for (int k = 0; k < 4; k++) begin
      cand[10+k] = disp[8*k +: 8];
      cen[10+k]  = (3'(k) < disp_len);
      cand[14+k] = imm[8*k +: 8];
      cen[14+k]  = (3'(k) < imm_len);
    end
  end

  assign len_calc = 5'(lr_en) + 5'(seg_en) + 5'(osz_en) + 5'(asz_en) + 5'(rex_en)
                  + 5'(opc_len) + 5'(modrm_en) + 5'(sib_en) + 5'(disp_len) + 5'(imm_len);

  assign bad = (len_calc > 5'(MAX_LEN)) || (opc_len == 2'd0) || !size_ok(disp_len)
            || !size_ok(imm_len) || (sib_en && !modrm_en);

  always_comb begin
    logic [4:0] pos;
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    buf_d   = buf_q;
    pos     = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (bad) begin
            state_d = ERR;
          end else begin
            state_d = EMIT;
            idx_d   = '0;
            len_d   = len_calc[3:0];
            // Compact the enabled bytes into the buffer front-to-back.
            for (int j = 0; j < 18; j++) begin
              if (cen[j]) begin
                if (pos < 5'(MAX_LEN)) buf_d[pos[3:0]] = cand[j];
                pos = pos + 5'd1;
              end
            end
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == len_q - 4'd1) state_d = IDLE;
          else                       idx_d   = idx_q + 4'd1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_byte  = (state_q == EMIT) ? buf_q[idx_q] : 8'h00;
  assign out_last  = (state_q == EMIT) && (idx_q == len_q - 4'd1);
  assign out_len   = len_q;
  assign err       = (state_q == ERR);

endmodule

// File: tb/tb_ins_encoder.sv
// Directed bench for ins_encoder: expected byte streams queued at issue, compared as bytes appear.
module tb_ins_encoder;

  logic        clk, reset, in_valid, in_ready;
  logic        lr_en, seg_en, osz_en, asz_en, rex_en;
  logic [7:0]  lr_byte, seg_byte, rex_byte;
  logic [23:0] opc;
  logic [1:0]  opc_len;
  logic        modrm_en, sib_en;
  logic [7:0]  modrm, sib;
  logic [31:0] disp, imm;
  logic [2:0]  disp_len, imm_len;
  logic        out_valid, out_ready, out_last, err;
  logic [7:0]  out_byte;
  logic [3:0]  out_len;

  ins_encoder #(.MAX_LEN(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .lr_en(lr_en), .seg_en(seg_en), .osz_en(osz_en), .asz_en(asz_en), .rex_en(rex_en),
    .lr_byte(lr_byte), .seg_byte(seg_byte), .rex_byte(rex_byte),
    .opc(opc), .opc_len(opc_len), .modrm_en(modrm_en), .sib_en(sib_en),
    .modrm(modrm), .sib(sib), .disp(disp), .imm(imm),
    .disp_len(disp_len), .imm_len(imm_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .out_len(out_len), .err(err)
  );

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [3:0] len;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stage[$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic       mon_en = 1'b0;
  logic       bp_en = 1'b0;
  logic       stalled_prev = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_last = 1'b0;
  exp_t       e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  task automatic clear_fields();
    {lr_en, seg_en, osz_en, asz_en, rex_en, modrm_en, sib_en} = '0;
    {lr_byte, seg_byte, rex_byte, modrm, sib} = '0;
    opc = '0; opc_len = 2'd0; disp = '0; imm = '0; disp_len = 3'd0; imm_len = 3'd0;
  endtask

  task automatic commit();
    exp_t x;
    for (int i = 0; i < stage.size(); i++) begin
      x.b = stage[i];
      x.last = (i == stage.size() - 1);
      x.len = 4'(stage.size());
      exp_q.push_back(x);
    end
    stage.delete();
  endtask

  // Returns one step into cycle N+1, after the handshake edge; inputs are then trashed.
  task automatic issue();
    int t = 0;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("issue_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    {lr_en, seg_en, osz_en, asz_en, rex_en, modrm_en, sib_en} = 7'($urandom);
    {lr_byte, seg_byte, rex_byte, modrm} = $urandom;
    opc = 24'($urandom); opc_len = 2'($urandom); disp = $urandom; imm = $urandom;
    disp_len = 3'($urandom); imm_len = 3'($urandom);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk(tag, (exp_q.size() == 0 && in_ready), 1'b1);
  endtask

  task automatic err_case(input string tag);
    issue();
    chk({tag, "_err"}, err, 1'b1);
    chk({tag, "_novld"}, out_valid, 1'b0);
    chk({tag, "_busy"}, in_ready, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_err_gone"}, err, 1'b0);
    chk({tag, "_ready"}, in_ready, 1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          chk("byte", out_byte, e.b);
          chk("last", out_last, e.last);
          chk("len", out_len, e.len);
          if (out_ready) void'(exp_q.pop_front());
        end
        if (stalled_prev) begin
          chk("hold_byte", out_byte, prev_byte);
          chk("hold_last", out_last, prev_last);
        end
        stalled_prev = !out_ready;
        prev_byte = out_byte;
        prev_last = out_last;
      end else begin
        if (stalled_prev) chk("hold_valid", out_valid, 1'b1);
        stalled_prev = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    clear_fields();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_byte", out_byte, 8'h00);
    chk("rst_len", out_len, 4'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1'b1);
    mon_en = 1'b1;

    // Single-byte NOP
    clear_fields(); opc = 24'h900000; opc_len = 2'd1;
    stage.push_back(8'h90); commit();
    issue();
    chk("min_valid", out_valid, 1'b1);
    chk("min_byte", out_byte, 8'h90);
    chk("min_last", out_last, 1'b1);
    chk("min_len", out_len, 4'd1);
    @(posedge clk); #1;
    chk("min_ready", in_ready, 1'b1);
    chk("min_done", out_valid, 1'b0);
    drain("min_drain");

    // Every field class in order
    clear_fields();
    lr_en = 1; lr_byte = 8'hF0; seg_en = 1; seg_byte = 8'h2E; osz_en = 1;
    rex_en = 1; rex_byte = 8'h48; opc = 24'h0FAF00; opc_len = 2'd2;
    modrm_en = 1; modrm = 8'h04; sib_en = 1; sib = 8'h24; disp = 32'h10; disp_len = 3'd1;
    foreach (stage[i]) stage.delete(i);
    stage = '{8'hF0, 8'h2E, 8'h66, 8'h48, 8'h0F, 8'hAF, 8'h04, 8'h24, 8'h10};
    commit();
    issue();
    drain("full_drain");

    // Random backpressure on a 32-bit immediate
    bp_en = 1'b1;
    clear_fields(); opc = 24'hB80000; opc_len = 2'd1; imm = 32'h12345678; imm_len = 3'd4;
    stage = '{8'hB8, 8'h78, 8'h56, 8'h34, 8'h12}; commit();
    issue();
    drain("bp_drain");
    bp_en = 1'b0;

    // Length 18 overflows
    clear_fields();
    {lr_en, seg_en, osz_en, asz_en, rex_en, modrm_en, sib_en} = '1;
    opc = 24'h0F3A0F; opc_len = 2'd3; disp_len = 3'd4; imm_len = 3'd4;
    err_case("ovf18");

    clear_fields(); opc = 24'h8B0000; opc_len = 2'd1; modrm_en = 1; disp_len = 3'd3;
    err_case("disp3");
    clear_fields(); opc = 24'h8B0000; opc_len = 2'd1; sib_en = 1;
    err_case("sib_nomodrm");
    clear_fields(); opc_len = 2'd0;
    err_case("opc0");

    // Legal after rejects, under backpressure, low bytes only
    bp_en = 1'b1;
    clear_fields(); osz_en = 1; asz_en = 1; opc = 24'h8B0000; opc_len = 2'd1;
    modrm_en = 1; modrm = 8'h45; disp = 32'h1234ABCD; disp_len = 3'd2;
    imm = 32'hFFFF5678; imm_len = 3'd2;
    stage = '{8'h66, 8'h67, 8'h8B, 8'h45, 8'hCD, 8'hAB, 8'h78, 8'h56}; commit();
    issue();
    drain("post_err_drain");
    bp_en = 1'b0;

    // Exactly MAX_LEN bytes, then one more
    clear_fields();
    lr_en = 1; lr_byte = 8'hF3; seg_en = 1; seg_byte = 8'h3E; osz_en = 1; asz_en = 1;
    rex_en = 1; rex_byte = 8'h41; opc = 24'h0F3800; opc_len = 2'd3;
    modrm_en = 1; modrm = 8'h44; sib_en = 1; sib = 8'h88;
    disp = 32'h11223344; disp_len = 3'd4; imm = 32'h000000AA; imm_len = 3'd1;
    stage = '{8'hF3, 8'h3E, 8'h66, 8'h67, 8'h41, 8'h0F, 8'h38, 8'h00, 8'h44, 8'h88,
              8'h44, 8'h33, 8'h22, 8'h11, 8'hAA};
    commit();
    issue();
    drain("len15_drain");
    imm_len = 3'd2;
    lr_en = 1; seg_en = 1; osz_en = 1; asz_en = 1; rex_en = 1; modrm_en = 1; sib_en = 1;
    opc_len = 2'd3; disp_len = 3'd4;
    err_case("len16");

    // Reset while the third of six bytes is on the output
    clear_fields(); opc = 24'hC70000; opc_len = 2'd1; modrm_en = 1; modrm = 8'h05;
    imm = 32'hDEADBEEF; imm_len = 3'd4;
    stage = '{8'hC7, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE}; commit();
    issue();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_third", out_byte, 8'hEF);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_byte", out_byte, 8'h00);
    chk("mid_rst_last", out_last, 1'b0);
    chk("mid_rst_len", out_len, 4'd0);
    chk("mid_rst_err", err, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_quiet", out_valid, 1'b0);

    clear_fields(); opc = 24'hC30000; opc_len = 2'd1;
    stage = '{8'hC3}; commit();
    issue();
    chk("after_rst_byte", out_byte, 8'hC3);
    drain("after_rst_drain");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
